// File: rtl/cpu_load_return_if.sv
//==============================================================================
// Module  : cpu_load_return_if
// Brief   : Load-issue, memory-response and regfile write-slot signals of the
//           load-return buffer. The master modport drives the buffer's inputs.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface cpu_load_return_if;
  logic        ld_issue;
  logic [4:0]  ld_dest;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [1:0]  ld_offset;
  logic        ld_full;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        p4_writes;
  logic        cpu_ready;
  logic [31:0] read_data;
  logic [4:0]  read_dest;
  logic        ld_pending;
  logic        resp_err;

  modport master (
    output ld_issue, ld_dest, ld_size, ld_signed, ld_offset,
    output mem_rvalid, mem_rdata, p4_writes,
    input  ld_full, cpu_ready, read_data, read_dest, ld_pending, resp_err
  );

  modport slave (
    input  ld_issue, ld_dest, ld_size, ld_signed, ld_offset,
    input  mem_rvalid, mem_rdata, p4_writes,
    output ld_full, cpu_ready, read_data, read_dest, ld_pending, resp_err
  );
endinterface

`default_nettype wire

// File: rtl/cpu_load_return.sv
//==============================================================================
// Module  : cpu_load_return
// Brief   : In-order load-return buffer: records issued loads, formats memory
//           responses and drains them into idle regfile write-port slots.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_load_return #(
  parameter int DEPTH = 4
) (
  input  wire logic             clock,
  input  wire logic             resetn,
  cpu_load_return_if.slave      bus
);

  localparam int             c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW:0]  c_FULL = (c_AW+1)'(DEPTH);

  logic [c_AW:0]      r_iptr;
  logic [c_AW:0]      r_rptr;
  logic [c_AW:0]      r_optr;
  logic [DEPTH-1:0]   r_dvalid;
  logic               r_resp_err;

  logic [4:0]         r_dest   [DEPTH];
  logic [1:0]         r_size   [DEPTH];
  logic               r_signed [DEPTH];
  logic [1:0]         r_offset [DEPTH];
  logic [31:0]        r_data   [DEPTH];

  logic [c_AW-1:0]    w_iidx;
  logic [c_AW-1:0]    w_ridx;
  logic [c_AW-1:0]    w_oidx;
  logic [c_AW:0]      w_count;
  logic               w_full;
  logic               w_nonempty;
  logic               w_issue;
  logic               w_resp;
  logic               w_retire;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_fmt;

  assign w_iidx     = r_iptr[c_AW-1:0];
  assign w_ridx     = r_rptr[c_AW-1:0];
  assign w_oidx     = r_optr[c_AW-1:0];
  assign w_count    = r_iptr - r_optr;
  assign w_full     = (w_count == c_FULL);
  assign w_nonempty = (w_count != '0);

  assign w_issue  = bus.ld_issue && !w_full;
  assign w_resp   = bus.mem_rvalid && (r_rptr != r_iptr);
  assign w_retire = w_nonempty && r_dvalid[w_oidx] && !bus.p4_writes;

  // Align and extend the raw word using the metadata of the entry awaiting data
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    w_fmt  = bus.mem_rdata;
    case (r_size[w_ridx])
      2'd0: begin
        case (r_offset[w_ridx])
          2'd0:    w_byte = bus.mem_rdata[7:0];
          2'd1:    w_byte = bus.mem_rdata[15:8];
          2'd2:    w_byte = bus.mem_rdata[23:16];
          default: w_byte = bus.mem_rdata[31:24];
        endcase
        w_fmt = {{24{r_signed[w_ridx] & w_byte[7]}}, w_byte};
      end
      2'd1: begin
        w_half = r_offset[w_ridx][1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_fmt  = {{16{r_signed[w_ridx] & w_half[15]}}, w_half};
      end
      default: w_fmt = bus.mem_rdata;
    endcase
  end

  // Issue, response and retire always address distinct entries
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_iptr     <= '0;
      r_rptr     <= '0;
      r_optr     <= '0;
      r_dvalid   <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_issue) begin
        r_iptr           <= r_iptr + c_ONE;
        r_dvalid[w_iidx] <= 1'b0;
      end
      if (w_resp) begin
        r_rptr           <= r_rptr + c_ONE;
        r_dvalid[w_ridx] <= 1'b1;
      end else if (bus.mem_rvalid) begin
        r_resp_err <= 1'b1;
      end
      if (w_retire) begin
        r_optr           <= r_optr + c_ONE;
        r_dvalid[w_oidx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_issue) begin
      r_dest[w_iidx]   <= bus.ld_dest;
      r_size[w_iidx]   <= bus.ld_size;
      r_signed[w_iidx] <= bus.ld_signed;
      r_offset[w_iidx] <= bus.ld_offset;
    end
    if (w_resp) begin
      r_data[w_ridx] <= w_fmt;
    end
  end

  assign bus.ld_full    = w_full;
  assign bus.ld_pending = w_nonempty;
  assign bus.cpu_ready  = w_retire;
  assign bus.read_data  = w_retire ? r_data[w_oidx] : 32'h0;
  assign bus.read_dest  = w_retire ? r_dest[w_oidx] : 5'h00;
  assign bus.resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: doc/cpu_load_return.md
# cpu_load_return

Load-return buffer feeding the complete (p5) stage. Records each issued load's destination and format, captures in-order memory read responses, aligns and extends them, then drains one entry per cycle into idle regfile write-port slots. It drives the `cpu_ready` / `read_data` pair that the complete stage muxes onto the write port.

## Interface
- `DEPTH`, 4: maximum outstanding loads. Power of two, ≥2.
- `clock`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ld_issue`  in  1  a load leaves the execute stage this cycle.
- `ld_dest`  in  5  destination register of the issued load.
- `ld_size`  in  2  access size.
  - 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- `ld_signed`  in  1  sign-extend byte/half when 1; zero-extend when 0.
- `ld_offset`  in  2  address bits [1:0] of the load.
- `ld_full`  out  1  DEPTH loads outstanding; pipeline must hold further loads.
- `mem_rvalid`  in  1  memory read response valid; responses arrive in issue order.
- `mem_rdata`  in  32  raw aligned 32-bit word from memory.
- `p4_writes`  in  1  p4 op writes the regfile this cycle (slot busy).
- `cpu_ready`  out  1  buffer owns the write port this cycle.
- `read_data`  out  32  formatted load result; 0 when `cpu_ready`=0.
- `read_dest`  out  5  destination register; 0 when `cpu_ready`=0.
- `ld_pending`  out  1  at least one load is issued and not yet retired (hazard interlock).
- `resp_err`  out  1  sticky: a response arrived with no outstanding load.

## Operation
- Circular queue of DEPTH entries. Each entry holds: dest, size, signed, offset, data[31:0], dvalid.
- Three pointers, each log2(DEPTH)+1 bits, wrapping modulo 2·DEPTH:
  - `iptr`: issue.
  - `rptr`: response.
  - `optr`: retire.
- Derived values:
  - count = iptr−optr.
  - `ld_full` = (count==DEPTH), combinational from registered pointers.
  - `ld_pending` = (count≠0).
- Issue:
  - When `ld_issue` && !`ld_full`: write metadata at iptr, clear dvalid, iptr++.
  - `ld_issue` while full is ignored and no state changes, even if a retire occurs the same cycle.
- Response:
  - When `mem_rvalid` and rptr≠iptr (registered values): format `mem_rdata` per the entry at rptr, store it, set dvalid, rptr++.
  - When `mem_rvalid` and rptr==iptr: the response is dropped and `resp_err` is set; only reset clears it.
- Formatting:
  - Byte: `mem_rdata[8·offset+7 : 8·offset]`.
  - Half: offset[1] selects bits [31:16], else [15:0]; offset[0] is ignored.
  - Extension: sign-extend from the top bit of the selected field when signed, otherwise zero-extend.
  - Word: unchanged.
- Retire:
  - `cpu_ready` = (count≠0) && dvalid[optr] && !`p4_writes`. This is combinational, since the complete stage samples it in the same cycle.
  - When `cpu_ready`: `read_data` and `read_dest` come from the entry at optr; optr++ and dvalid is cleared at the clock edge.
- Simultaneous events: issue, response and retire may all occur in one cycle. Each acts on a different entry and they are independent.

## Timing
- Reset (async assert, sync release) forces:
  - all pointers = 0 and all dvalid = 0;
  - `resp_err` = 0;
  - therefore `cpu_ready`=0, `read_data`=0, `read_dest`=0, `ld_full`=0, `ld_pending`=0.
  - Reset mid-operation discards all entries.
- Issue at cycle N makes the entry visible to `ld_full` and `ld_pending` at N+1. A response is accepted for it no earlier than N+1.
- A response at cycle M is retirable no earlier than M+1. Minimum issue-to-`cpu_ready` latency is 2 cycles.
- Throughput: one issue, one response and one retire per cycle.
- Backpressure: `p4_writes`=1 holds `cpu_ready` low, and the head entry waits indefinitely.
- Full boundary: at count==DEPTH, a retire in cycle N deasserts `ld_full` in N+1.

## Test plan
- **Basic word load:** issue dest=5, size=2 at cycle 0; response 0xDEADBEEF at cycle 3; `p4_writes`=0.
  - Expect `cpu_ready`=1, `read_dest`=5, `read_data`=0xDEADBEEF at cycle 4 only, then `ld_pending`=0.
- **Byte/half formatting:** `mem_rdata`=0x80F1_7F82.
  - Signed byte, offset 0 → 0xFFFFFF82.
  - Unsigned byte, offset 3 → 0x00000080.
  - Signed half, offset 2 → 0xFFFF80F1.
  - Signed half, offset 0 → 0x00007F82.
- **Full / backpressure:** issue 5 loads back-to-back with DEPTH=4.
  - Expect `ld_full`=1 from cycle 4 and the 5th issue ignored.
  - Return 4 responses with `p4_writes`=1 held: no `cpu_ready`.
  - Release `p4_writes`: 4 consecutive retires in issue order; `ld_full` drops the cycle after the first retire.
- **Simultaneous events:** with 2 entries outstanding and head dvalid, assert issue, response and retire in the same cycle.
  - Expect count unchanged, correct order preserved, and no data lost.
- **Spurious response:** `mem_rvalid` with nothing outstanding.
  - Expect `resp_err`=1 sticky, no `cpu_ready`, and the next normal load unaffected.
- **Reset mid-operation:** assert `resetn`=0 with 3 pending loads.
  - Expect all outputs 0 immediately, and after release the first issue lands in entry 0.
